// File: rtl/data_mem_port.sv
// -----------------------------------------------------------------------------
// data_mem_port
//
// Data-memory access unit between the MEM stage and a word-wide data RAM.
// A load/store presented by EX/MEM is latched onto the bus registers and run
// through a req/ack handshake; the pipeline is stalled until the access
// finishes, then the writeback register and value are handed to MEM/WB.
// Non-memory instructions pass straight through with zero latency.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-low reset
//   i_readEnable        load request
//   i_writeEnable       store request (wins over read)
//   i_addr, i_sel       word address, byte-lane mask
//   i_signExt           load extension mode (1 = signed)
//   i_writeData         lane-aligned store data
//   i_result, i_regDest ALU result / writeback register for passthrough
//   o_stall             freezes the upstream pipeline registers
//   o_regDest, o_value  writeback register and value to MEM/WB
//   o_bus*              RAM request, write strobe, address, lanes, data
//   i_busAck, i_busRData one-cycle completion and read data
//   o_error             sticky fault (timeout or illegal load lane mask)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access in flight; passthrough, or accept a new request
// BUSY  | request on the bus, waiting for ack or timeout
// DONE  | access finished; present result, pipeline advances this edge
// -----------------------------------------------------------------------------
module data_mem_port #(
  parameter int ADDR_WIDTH = 30,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_readEnable,
  input  logic                  i_writeEnable,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [3:0]            i_sel,
  input  logic                  i_signExt,
  input  logic [31:0]           i_writeData,
  input  logic [31:0]           i_result,
  input  logic [4:0]            i_regDest,
  output logic                  o_stall,
  output logic [4:0]            o_regDest,
  output logic [31:0]           o_value,
  output logic                  o_busReq,
  output logic                  o_busWe,
  output logic [ADDR_WIDTH-1:0] o_busAddr,
  output logic [3:0]            o_busSel,
  output logic [31:0]           o_busWData,
  input  logic                  i_busAck,
  input  logic [31:0]           i_busRData,
  output logic                  o_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Down-counter loaded on entry to BUSY; terminal count 0 means the
  // TIMEOUT-th BUSY cycle has passed without an ack.
  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  tmo_cnt;
  logic [31:0] rdata_q;
  logic        sign_ext_q;
  logic [4:0]  reg_dest_q;

  logic        req_valid;
  logic        sel_legal;
  logic [7:0]  byte_f;
  logic [15:0] half_f;
  logic [31:0] load_value;

  assign req_valid = i_readEnable | i_writeEnable;

  always_comb begin
    case (o_busSel)
      4'b1111, 4'b0011, 4'b1100,
      4'b0001, 4'b0010, 4'b0100, 4'b1000: sel_legal = 1'b1;
      default:                            sel_legal = 1'b0;
    endcase
  end

  // Move the selected field to bit 0 and extend it; illegal masks return
  // the whole word (the error flag is raised when the data is latched).
  always_comb begin
    byte_f     = 8'h00;
    half_f     = 16'h0000;
    load_value = rdata_q;
    case (o_busSel)
      4'b0011: begin
        half_f     = rdata_q[15:0];
        load_value = {{16{sign_ext_q & half_f[15]}}, half_f};
      end
      4'b1100: begin
        half_f     = rdata_q[31:16];
        load_value = {{16{sign_ext_q & half_f[15]}}, half_f};
      end
      4'b0001: begin
        byte_f     = rdata_q[7:0];
        load_value = {{24{sign_ext_q & byte_f[7]}}, byte_f};
      end
      4'b0010: begin
        byte_f     = rdata_q[15:8];
        load_value = {{24{sign_ext_q & byte_f[7]}}, byte_f};
      end
      4'b0100: begin
        byte_f     = rdata_q[23:16];
        load_value = {{24{sign_ext_q & byte_f[7]}}, byte_f};
      end
      4'b1000: begin
        byte_f     = rdata_q[31:24];
        load_value = {{24{sign_ext_q & byte_f[7]}}, byte_f};
      end
      default: load_value = rdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      tmo_cnt    <= 8'd0;
      o_busReq   <= 1'b0;
      o_busWe    <= 1'b0;
      o_busAddr  <= '0;
      o_busSel   <= 4'b0000;
      o_busWData <= 32'h0;
      rdata_q    <= 32'h0;
      sign_ext_q <= 1'b0;
      reg_dest_q <= 5'd0;
      o_error    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            o_busReq   <= 1'b1;
            o_busWe    <= i_writeEnable;
            o_busAddr  <= i_addr;
            o_busSel   <= i_sel;
            o_busWData <= i_writeData;
            sign_ext_q <= i_signExt;
            reg_dest_q <= i_regDest;
            tmo_cnt    <= TMO_LOAD;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (i_busAck) begin
            o_busReq <= 1'b0;
            rdata_q  <= i_busRData;
            if (!o_busWe && !sel_legal) o_error <= 1'b1;
            state    <= DONE;
          end else if (tmo_cnt == 8'd0) begin
            o_busReq <= 1'b0;
            rdata_q  <= 32'h0;
            o_error  <= 1'b1;
            state    <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt - 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stall is combinational in IDLE so the request cycle itself is frozen;
  // it is held off while reset is asserted.
  always_comb begin
    o_stall   = 1'b0;
    o_regDest = 5'd0;
    o_value   = 32'h0;
    case (state)
      IDLE: begin
        o_stall   = rst & req_valid;
        o_regDest = req_valid ? 5'd0 : i_regDest;
        o_value   = i_result;
      end
      BUSY: begin
        o_stall = 1'b1;
      end
      DONE: begin
        if (!o_busWe) begin
          o_regDest = reg_dest_q;
          o_value   = load_value;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_mem_port.sv
module tb_data_mem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_readEnable, i_writeEnable;
  logic [29:0] i_addr;
  logic [3:0]  i_sel;
  logic        i_signExt;
  logic [31:0] i_writeData, i_result;
  logic [4:0]  i_regDest;
  logic        o_stall;
  logic [4:0]  o_regDest;
  logic [31:0] o_value;
  logic        o_busReq, o_busWe;
  logic [29:0] o_busAddr;
  logic [3:0]  o_busSel;
  logic [31:0] o_busWData;
  logic        i_busAck;
  logic [31:0] i_busRData;
  logic        o_error;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_port #(.ADDR_WIDTH(30), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_readEnable(i_readEnable), .i_writeEnable(i_writeEnable),
    .i_addr(i_addr), .i_sel(i_sel), .i_signExt(i_signExt),
    .i_writeData(i_writeData), .i_result(i_result), .i_regDest(i_regDest),
    .o_stall(o_stall), .o_regDest(o_regDest), .o_value(o_value),
    .o_busReq(o_busReq), .o_busWe(o_busWe), .o_busAddr(o_busAddr),
    .o_busSel(o_busSel), .o_busWData(o_busWData),
    .i_busAck(i_busAck), .i_busRData(i_busRData), .o_error(o_error)
  );

  typedef struct {
    logic        re;
    logic        we;
    logic [29:0] addr;
    logic [3:0]  sel;
    logic        sext;
    logic [31:0] wdata;
    logic [31:0] result;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          k;
    logic [31:0] exp_value;
    logic [4:0]  exp_rd;
    int          exp_stalls;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to the next cycle; inputs are driven shortly after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    i_readEnable  = 1'b0;
    i_writeEnable = 1'b0;
    i_busAck      = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  stalls;
    int  reqs;
    bit  done;
    string tag;
    tag = $sformatf("v%0d", idx);
    i_readEnable  = v.re;
    i_writeEnable = v.we;
    i_addr        = v.addr;
    i_sel         = v.sel;
    i_signExt     = v.sext;
    i_writeData   = v.wdata;
    i_result      = v.result;
    i_regDest     = v.rd;
    i_busAck      = 1'b0;
    i_busRData    = 32'h0;
    #1;
    if (!v.re && !v.we) begin
      chk({tag, "_pass_value"}, o_value, v.exp_value);
      chk({tag, "_pass_rd"}, {27'd0, o_regDest}, {27'd0, v.exp_rd});
      chk({tag, "_pass_stall"}, {31'd0, o_stall}, 32'd0);
      tick();
      return;
    end
    chk({tag, "_req_rd"}, {27'd0, o_regDest}, 32'd0);
    stalls = o_stall ? 1 : 0;
    reqs   = 0;
    done   = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      i_busAck   = (c == v.k);
      i_busRData = (c == v.k) ? v.rdata : 32'hDEAD_DEAD;
      #1;
      if (o_busReq) begin
        reqs++;
        chk({tag, "_bus_we"}, {31'd0, o_busWe}, {31'd0, v.we});
        chk({tag, "_bus_addr"}, {2'd0, o_busAddr}, {2'd0, v.addr});
        chk({tag, "_bus_sel"}, {28'd0, o_busSel}, {28'd0, v.sel});
        if (v.we) chk({tag, "_bus_wdata"}, o_busWData, v.wdata);
      end
      if (o_stall) stalls++;
      else begin
        done = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_done_timeout: got no DONE expected DONE within 40 cycles", tag);
    end
    chk({tag, "_stalls"}, stalls, v.exp_stalls);
    chk({tag, "_req_cycles"}, reqs, v.k + 1);
    chk({tag, "_value"}, o_value, v.exp_value);
    chk({tag, "_rd"}, {27'd0, o_regDest}, {27'd0, v.exp_rd});
    chk({tag, "_err"}, {31'd0, o_error}, {31'd0, v.exp_err});
    idle_inputs();
    tick();
    #1;
    chk({tag, "_no_reissue"}, {31'd0, o_busReq}, 32'd0);
    chk({tag, "_idle_stall"}, {31'd0, o_stall}, 32'd0);
  endtask

  initial begin
    int stalls;
    int reqs;
    bit done;

    // re we addr sel sext wdata result rd rdata k exp_value exp_rd stalls err
    vecs[0]  = '{1'b0, 1'b0, 30'h0,  4'b0000, 1'b0, 32'h0, 32'h1234_5678, 5'd5, 32'h0, 0, 32'h1234_5678, 5'd5, 0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 30'h20, 4'b0100, 1'b1, 32'h0, 32'h0, 5'd9, 32'h00A5_0000, 3, 32'hFFFF_FFA5, 5'd9, 5, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 30'h20, 4'b0100, 1'b0, 32'h0, 32'h0, 5'd9, 32'h00A5_0000, 3, 32'h0000_00A5, 5'd9, 5, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 30'h10, 4'b1100, 1'b0, 32'hBEEF_0000, 32'h0, 5'd7, 32'h0, 0, 32'h0, 5'd0, 2, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 30'h31, 4'b1100, 1'b1, 32'h0, 32'h0, 5'd4, 32'h8001_1234, 1, 32'hFFFF_8001, 5'd4, 3, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 30'h32, 4'b0011, 1'b0, 32'h0, 32'h0, 5'd6, 32'h8001_F00D, 0, 32'h0000_F00D, 5'd6, 2, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 30'h3FFF_FFFF, 4'b1111, 1'b1, 32'h0, 32'h0, 5'd31, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 5'd31, 4, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 30'h40, 4'b1000, 1'b1, 32'h0, 32'h0, 5'd1, 32'h8000_0000, 0, 32'hFFFF_FF80, 5'd1, 2, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 30'h41, 4'b0001, 1'b1, 32'h0, 32'h0, 5'd2, 32'hFFFF_FF7F, 1, 32'h0000_007F, 5'd2, 3, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 30'h55, 4'b1111, 1'b0, 32'h1357_9BDF, 32'h0, 5'd8, 32'hFFFF_FFFF, 0, 32'h0, 5'd0, 2, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 30'h0,  4'b0000, 1'b0, 32'h0, 32'hCAFE_F00D, 5'd0, 32'h0, 0, 32'hCAFE_F00D, 5'd0, 0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 30'h66, 4'b0101, 1'b1, 32'h0, 32'h0, 5'd3, 32'h8234_5678, 0, 32'h8234_5678, 5'd3, 2, 1'b1};

    // Reset held two cycles with a pending load.
    rst = 1'b0;
    i_readEnable = 1'b1; i_writeEnable = 1'b0;
    i_addr = 30'h0; i_sel = 4'b1111; i_signExt = 1'b0;
    i_writeData = 32'h0; i_result = 32'h0; i_regDest = 5'd0;
    i_busAck = 1'b0; i_busRData = 32'h0;
    tick();
    tick();
    #1;
    chk("rst_busreq", {31'd0, o_busReq}, 32'd0);
    chk("rst_error", {31'd0, o_error}, 32'd0);
    chk("rst_stall", {31'd0, o_stall}, 32'd0);
    chk("rst_busaddr", {2'd0, o_busAddr}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rel_stall", {31'd0, o_stall}, 32'd1);
    i_readEnable = 1'b0;
    tick();
    #1;
    chk("rel_busreq", {31'd0, o_busReq}, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset mid-BUSY: the access aborts and a late ack is ignored.
    i_readEnable = 1'b1; i_sel = 4'b1111; i_addr = 30'h77; i_regDest = 5'd12;
    tick();
    idle_inputs();
    #1;
    chk("mid_busreq_on", {31'd0, o_busReq}, 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    i_busAck = 1'b1; i_busRData = 32'h1111_2222;
    i_result = 32'h0BAD_F00D; i_regDest = 5'd13;
    #1;
    chk("mid_busreq_off", {31'd0, o_busReq}, 32'd0);
    chk("mid_stall", {31'd0, o_stall}, 32'd0);
    chk("mid_value", o_value, 32'h0BAD_F00D);
    chk("mid_err_cleared", {31'd0, o_error}, 32'd0);
    tick();
    i_busAck = 1'b0;
    #1;
    chk("late_ack_busreq", {31'd0, o_busReq}, 32'd0);
    chk("late_ack_stall", {31'd0, o_stall}, 32'd0);
    chk("late_ack_rd", {27'd0, o_regDest}, 32'd13);

    // Timeout: no ack ever; four request cycles then DONE with value 0.
    i_readEnable = 1'b1; i_sel = 4'b1111; i_addr = 30'h88; i_regDest = 5'd14;
    #1;
    stalls = o_stall ? 1 : 0;
    reqs = 0;
    done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      #1;
      if (o_busReq) reqs++;
      if (o_stall) stalls++;
      else begin
        done = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL tmo_done_timeout: got no DONE expected DONE within 40 cycles");
    end
    chk("tmo_req_cycles", reqs, 4);
    chk("tmo_stalls", stalls, 5);
    chk("tmo_value", o_value, 32'h0);
    chk("tmo_error", {31'd0, o_error}, 32'd1);
    idle_inputs();
    for (int c = 0; c < 5; c++) tick();
    #1;
    chk("tmo_error_held", {31'd0, o_error}, 32'd1);
    chk("tmo_busreq_idle", {31'd0, o_busReq}, 32'd0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("tmo_error_reset", {31'd0, o_error}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_port.md
# data_mem_port

Data-memory access unit between the pipeline's MEM stage and an external word-wide data RAM. It accepts the load/store request the EX/MEM register presents and runs a req/ack handshake with the RAM. It stalls the pipeline until the access completes, then hands the writeback register and value to MEM/WB. Non-memory instructions pass through combinationally with zero latency.

## Interface
- ADDR_WIDTH, 30: word-address width; the byte address is {addr, 2'b00}.
- TIMEOUT, 255: maximum BUSY cycles without ack before abort; range 1..255.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- i_readEnable  in  1  load request from EX/MEM
- i_writeEnable  in  1  store request; wins over read if both high
- i_addr  in  ADDR_WIDTH  word address
- i_sel  in  4  byte-lane mask; lane k = bits 8k+7:8k
- i_signExt  in  1  loads: 1 sign-extends, 0 zero-extends
- i_writeData  in  32  store data, already lane-aligned
- i_result  in  32  ALU result for non-memory instructions
- i_regDest  in  5  writeback register (0 = none)
- o_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- o_regDest  out  5  to MEM/WB
- o_value  out  32  to MEM/WB
- o_busReq, o_busWe  out  1  RAM request and write strobe
- o_busAddr  out  ADDR_WIDTH; o_busSel  out  4; o_busWData  out  32
- i_busAck  in  1  RAM completion, one cycle
- i_busRData  in  32  read data, valid with ack
- o_error  out  1  sticky fault flag

## Operation
- Three-state FSM: IDLE, BUSY, DONE.
- IDLE with no enable:
  - o_value = i_result, o_regDest = i_regDest, o_stall = 0.
- IDLE with an enable:
  - o_stall = 1 combinationally; o_regDest = 0.
  - At the edge, latch addr/sel/we/wdata/signExt/regDest onto the bus registers, set o_busReq = 1 and go to BUSY.
- BUSY:
  - o_stall = 1; bus outputs held stable.
  - On i_busAck = 1, latch i_busRData, drop o_busReq at the edge and go to DONE.
  - The timeout counter increments each BUSY cycle. When it reaches TIMEOUT without ack: drop o_busReq, set latched data = 0, set o_error, go to DONE.
- DONE:
  - o_stall = 0 and the pipeline advances at this edge.
  - Load: o_regDest = latched regDest, o_value = extracted data.
  - Store: o_regDest = 0, o_value = 0.
  - Next state is always IDLE; the still-present old request is not re-issued.
- Load extraction:
  - sel 1111 → whole word.
  - 0011 / 1100 → halfword from lanes 0-1 / 2-3.
  - Single-bit sel → that byte.
  - Shift the field to bit 0 and extend per signExt.
  - Any other sel pattern → treat as 1111 and set o_error.
- i_busAck outside BUSY is ignored.
- o_error is cleared only by reset.

## Timing
- Reset, while rst = 0 at an edge:
  - state IDLE, counter 0, o_busReq 0.
  - o_busWe/o_busAddr/o_busSel/o_busWData = 0, latched data 0, o_error 0.
- Reset during BUSY aborts the access; o_busReq is low from the next cycle.
- Request seen in IDLE in cycle N:
  - BUSY from N+1; ack at cycle N+1+k (k ≥ 0) → DONE at N+2+k → IDLE at N+3+k.
  - o_stall is high for cycles N..N+1+k: minimum 2 stall cycles, 3 total occupancy.
- Ack in the first BUSY cycle is legal (k = 0).
- o_busReq remains high through the ack cycle and is low the cycle after.
- Timeout: DONE is entered TIMEOUT+1 cycles after IDLE; the counter resets on entering BUSY.
- Back-to-back memory ops: the second request is seen in the IDLE cycle after DONE, giving one unstalled cycle between accesses.

## Test plan
- Reset: hold rst = 0 two cycles with i_readEnable = 1 → o_busReq = 0, o_error = 0, o_stall = 1 only after release.
- Passthrough: no enables, i_result = 32'h1234_5678, i_regDest = 5 → same-cycle o_value = 32'h1234_5678, o_regDest = 5, o_stall = 0.
- Signed byte load: i_sel = 0100, i_signExt = 1, ack after 3 cycles with rdata = 32'h00A5_0000, i_regDest = 9.
  - Required: o_stall high 5 cycles, then DONE with o_value = 32'hFFFF_FFA5, o_regDest = 9.
  - Repeat with signExt = 0 → 32'h0000_00A5.
- Store with immediate ack: i_writeEnable = 1, addr = 30'h10, sel = 1100, wdata = 32'hBEEF_0000.
  - Required: bus shows we = 1, addr 30'h10, sel 1100 for exactly one cycle; DONE with o_regDest = 0; exactly one request issued.
- Timeout: TIMEOUT = 4, never ack → o_busReq high 4 cycles, DONE with o_value = 0, o_error = 1 held until reset.
- Illegal sel 0101 on load, plus reset asserted mid-BUSY:
  - Illegal sel → o_error = 1, word returned.
  - Reset mid-BUSY → o_busReq low the next cycle, state IDLE, late ack ignored.
